phase_scheduler: RTL

//  Round-robin scheduler for the intersection's signal phases. Arbitrates latched vehicle-sensor

---
 rtl/traffic_pkg.sv | 43 ++++
 rtl/sec_prescaler.sv | 28 ++
 rtl/phase_scheduler.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - light codes, phase ids and scheduler state encodings shared by the intersection blocks
package traffic_pkg;

   typedef enum logic [1:0] {
      RED    = 2'b00,
      YELLOW = 2'b01,
      GREEN  = 2'b10
   } light_t;

   typedef enum logic [1:0] {
      PH_TH  = 2'd0,
      PH_NN  = 2'd1,
      PH_NS  = 2'd2,
      PH_PED = 2'd3
   } phase_t;

   typedef enum logic [1:0] {
      S_ALL_RED = 2'd0,
      S_GREEN   = 2'd1,
      S_YELLOW  = 2'd2,
      S_WALK    = 2'd3
   } state_t;

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   // Only the granted phase ever leaves RED, which is what keeps the vehicle lights mutually exclusive.
   function automatic light_t light_for(input phase_t ph, input state_t st, input phase_t g);
      if (g != ph) return RED;
      case (st)
         S_GREEN:  return GREEN;
         S_YELLOW: return YELLOW;
         default:  return RED;
      endcase
   endfunction

endpackage

// File: rtl/sec_prescaler.sv
// rtl/sec_prescaler.sv - one-cycle tick every CLK_HZ enabled cycles, restartable at interval boundaries
module sec_prescaler #(
   parameter int CLK_HZ = 10000
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic restart,
   output logic sec_tick
);

   localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

   logic [CW-1:0] cnt;

   assign sec_tick = enable && (cnt == LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (enable) begin
         if (restart || cnt == LAST) cnt <= '0;
         else                        cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/phase_scheduler.sv
// rtl/phase_scheduler.sv - round-robin phase arbiter and GREEN/YELLOW/ALL_RED/WALK sequencer
module phase_scheduler
   import traffic_pkg::*;
#(
   parameter int CLK_HZ    = 10000,
   parameter int MIN_GREEN = 5,
   parameter int MAX_GREEN = 20,
   parameter int YELLOW_T  = 3,
   parameter int ALL_RED_T = 1,
   parameter int PED_T     = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       req_th,
   input  logic       req_nn,
   input  logic       req_ns,
   input  logic       req_ped,
   output logic [1:0] light_th,
   output logic [1:0] light_nn,
   output logic [1:0] light_ns,
   output logic       light_ped,
   output logic [1:0] grant,
   output logic [3:0] pending
);

   localparam int TW = $clog2(max4(MAX_GREEN, YELLOW_T, ALL_RED_T, PED_T) + 1);
   localparam logic [TW-1:0] T_MAX   = TW'(MAX_GREEN);
   localparam logic [TW-1:0] T_YEL   = TW'(YELLOW_T);
   localparam logic [TW-1:0] T_AR    = TW'(ALL_RED_T);
   localparam logic [TW-1:0] T_PED   = TW'(PED_T);
   localparam logic [TW-1:0] T_EARLY = TW'(MAX_GREEN - MIN_GREEN);

   logic [3:0]    sync1, sync2;
   logic [3:0]    pending_q, busy, clr;
   state_t        state, nxt_state;
   phase_t        grant_q, nxt_grant, scan_ph;
   logic [TW-1:0] timer, timer_nx, nxt_timer;
   logic [1:0]    cand;
   logic          scan_hit, others_pending, sec_tick, restart;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= {req_ped, req_ns, req_nn, req_th};
         sync2 <= sync1;
      end
   end

   sec_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .restart  (restart),
      .sec_tick (sec_tick)
   );

   // Decisions look at the post-tick timer so every interval ends on the tick that exhausts it.
   assign timer_nx = (sec_tick && timer != '0) ? timer - TW'(1) : timer;

   always_comb begin
      scan_hit = 1'b0;
      scan_ph  = grant_q;
      cand     = '0;
      for (int k = 1; k <= 4; k++) begin
         cand = 2'(grant_q) + 2'(k);
         if (!scan_hit && pending_q[cand]) begin
            scan_hit = 1'b1;
            scan_ph  = phase_t'(cand);
         end
      end
   end

   assign others_pending = |(pending_q & ~(4'b0001 << grant_q));

   always_comb begin
      nxt_state = state;
      nxt_grant = grant_q;
      nxt_timer = timer;
      if (enable) begin
         nxt_timer = timer_nx;
         case (state)
            S_ALL_RED: begin
               if (timer_nx == '0 && scan_hit) begin
                  nxt_grant = scan_ph;
                  if (scan_ph == PH_PED) begin
                     nxt_state = S_WALK;
                     nxt_timer = T_PED;
                  end else begin
                     nxt_state = S_GREEN;
                     nxt_timer = T_MAX;
                  end
               end
            end
            S_GREEN: begin
               if (timer_nx == '0 || (timer_nx <= T_EARLY && others_pending)) begin
                  nxt_state = S_YELLOW;
                  nxt_timer = T_YEL;
               end
            end
            default: begin
               if (timer_nx == '0) begin
                  nxt_state = S_ALL_RED;
                  nxt_timer = T_AR;
               end
            end
         endcase
      end
   end

   assign restart = (nxt_state != state);

   // The phase being served cannot re-latch its own request; entry clears it and wins over a set.
   assign busy = (state == S_GREEN) ? (4'b0001 << grant_q) :
                 (state == S_WALK)  ? 4'b1000 : 4'b0000;
   assign clr  = (restart && (nxt_state == S_GREEN || nxt_state == S_WALK)) ?
                 (4'b0001 << nxt_grant) : 4'b0000;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_ALL_RED;
         timer     <= T_AR;
         grant_q   <= PH_PED;
         pending_q <= '0;
         light_th  <= RED;
         light_nn  <= RED;
         light_ns  <= RED;
         light_ped <= 1'b0;
      end else begin
         state     <= nxt_state;
         timer     <= nxt_timer;
         grant_q   <= nxt_grant;
         pending_q <= (pending_q | (sync2 & ~busy)) & ~clr;
         light_th  <= light_for(PH_TH, nxt_state, nxt_grant);
         light_nn  <= light_for(PH_NN, nxt_state, nxt_grant);
         light_ns  <= light_for(PH_NS, nxt_state, nxt_grant);
         light_ped <= (nxt_state == S_WALK);
      end
   end

   assign grant   = grant_q;
   assign pending = pending_q;

endmodule
